// File: rtl/address_sequencer.sv
// Address sequencer: steps a ROM/display address through a programmable
// window [LowAddr..HighAddr] on rising edges of the timer Enable tick.
// Supports run/stop, up/down, synchronous load, and loop or one-shot mode.
module address_sequencer #(
    parameter int AW   = 5,
    parameter bit LOOP = 1'b1
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Enable,
    input  logic          Run,
    input  logic          Dir,
    input  logic          Load,
    input  logic [AW-1:0] LoadAddr,
    input  logic [AW-1:0] LowAddr,
    input  logic [AW-1:0] HighAddr,
    output logic [AW-1:0] Address,
    output logic          AddrStrobe,
    output logic          Wrap,
    output logic          Err,
    output logic [1:0]    State
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } stateT;

    stateT         state;
    stateT         stateNext;
    logic [AW-1:0] addrNext;
    logic          wrapNext;
    logic          enableQ;
    logic          tick;
    logic          outside;
    logic          atUpEdge;
    logic          atDownEdge;

    // An inverted window is flagged regardless of reset or state.
    assign Err = (LowAddr > HighAddr);

    // A long Enable pulse still only counts once: only its rising edge is a tick.
    assign tick = Enable & ~enableQ;

    // Out-of-window is decided before any +/-1, so the step never overflows.
    assign outside    = (Address < LowAddr) || (Address > HighAddr);
    assign atUpEdge   = (Address == HighAddr);
    assign atDownEdge = (Address == LowAddr);

    assign State = state;

    // Next-state and next-address logic: Load beats tick, tick beats hold.
    always_comb begin
        stateNext = state;
        addrNext  = Address;
        wrapNext  = 1'b0;
        if (Load) begin
            addrNext  = LoadAddr;
            stateNext = Run ? RUN : IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (Run) begin
                        stateNext = RUN;
                    end
                end
                RUN: begin
                    if (!Run) begin
                        stateNext = IDLE;
                    end else if (tick && !Err) begin
                        if (outside) begin
                            addrNext = Dir ? HighAddr : LowAddr;
                        end else if (!Dir) begin
                            if (!atUpEdge) begin
                                addrNext = Address + AW'(1);
                            end else if (LOOP) begin
                                addrNext = LowAddr;
                                wrapNext = 1'b1;
                            end else begin
                                stateNext = DONE;
                                wrapNext  = 1'b1;
                            end
                        end else begin
                            if (!atDownEdge) begin
                                addrNext = Address - AW'(1);
                            end else if (LOOP) begin
                                addrNext = HighAddr;
                                wrapNext = 1'b1;
                            end else begin
                                stateNext = DONE;
                                wrapNext  = 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    if (!Run) begin
                        stateNext = IDLE;
                    end
                end
                default: begin
                    stateNext = IDLE;
                end
            endcase
        end
    end

    // State, address, strobe and wrap registers with asynchronous active-low reset.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            Address    <= '0;
            AddrStrobe <= 1'b0;
            Wrap       <= 1'b0;
            enableQ    <= 1'b0;
        end else begin
            state      <= stateNext;
            Address    <= addrNext;
            AddrStrobe <= (addrNext != Address);
            Wrap       <= wrapNext;
            enableQ    <= Enable;
        end
    end

endmodule

// File: tb/tb_address_sequencer.sv
// Bench for address_sequencer: a looping and a one-shot instance share the
// same stimulus and are compared against a window/offset model every cycle.
module tb_address_sequencer;

    localparam int AW = 5;

    logic          Clk = 1'b0;
    logic          rstN = 1'b1;
    logic          Enable = 1'b0;
    logic          Run = 1'b0;
    logic          Dir = 1'b0;
    logic          Load = 1'b0;
    logic [AW-1:0] LoadAddr = '0;
    logic [AW-1:0] LowAddr = '0;
    logic [AW-1:0] HighAddr = '0;

    logic [AW-1:0] addrO [2];
    logic          strobeO [2];
    logic          wrapO [2];
    logic          errO [2];
    logic [1:0]    stateO [2];

    int mAddr [2];
    int mState [2];
    int mStrobe [2];
    int mWrap [2];
    int mEnQ;

    int checks = 0;
    int errors = 0;
    int wrapSeen0 = 0;
    int strobeSeen0 = 0;

    // Free-running clock.
    always #5 Clk = ~Clk;

    address_sequencer #(.AW(AW), .LOOP(1'b1)) u0 (
        .Clk(Clk), .Reset(rstN), .Enable(Enable), .Run(Run), .Dir(Dir),
        .Load(Load), .LoadAddr(LoadAddr), .LowAddr(LowAddr), .HighAddr(HighAddr),
        .Address(addrO[0]), .AddrStrobe(strobeO[0]), .Wrap(wrapO[0]),
        .Err(errO[0]), .State(stateO[0])
    );

    address_sequencer #(.AW(AW), .LOOP(1'b0)) u1 (
        .Clk(Clk), .Reset(rstN), .Enable(Enable), .Run(Run), .Dir(Dir),
        .Load(Load), .LoadAddr(LoadAddr), .LowAddr(LowAddr), .HighAddr(HighAddr),
        .Address(addrO[1]), .AddrStrobe(strobeO[1]), .Wrap(wrapO[1]),
        .Err(errO[1]), .State(stateO[1])
    );

    task automatic checkValue(input string tag, input logic [31:0] obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            mAddr[k]   = 0;
            mState[k]  = 0;
            mStrobe[k] = 0;
            mWrap[k]   = 0;
        end
        mEnQ = 0;
    endtask

    // Window model: position is an offset from the edge we move away from,
    // advanced modulo the window size; offset 0 after advancing means a wrap.
    task automatic modelStep();
        int  a, na, ns, lo, hi, span, off, noff;
        bit  w, tickM, errM;
        tickM = (Enable == 1'b1) && (mEnQ == 0);
        lo    = int'(LowAddr);
        hi    = int'(HighAddr);
        errM  = lo > hi;
        for (int k = 0; k < 2; k++) begin
            a  = mAddr[k];
            na = a;
            ns = mState[k];
            w  = 1'b0;
            if (Load) begin
                na = int'(LoadAddr);
                ns = Run ? 1 : 0;
            end else if (mState[k] == 0) begin
                if (Run) ns = 1;
            end else if (mState[k] == 2) begin
                if (!Run) ns = 0;
            end else if (!Run) begin
                ns = 0;
            end else if (tickM && !errM) begin
                if (a < lo || a > hi) begin
                    na = Dir ? hi : lo;
                end else begin
                    span = hi - lo + 1;
                    off  = Dir ? (hi - a) : (a - lo);
                    noff = (off + 1) % span;
                    if (noff == 0) begin
                        w = 1'b1;
                        if (k == 1) ns = 2;
                        else na = Dir ? hi : lo;
                    end else begin
                        na = Dir ? (hi - noff) : (lo + noff);
                    end
                end
            end
            mStrobe[k] = (na != a) ? 1 : 0;
            mWrap[k]   = w ? 1 : 0;
            mAddr[k]   = na;
            mState[k]  = ns;
        end
        mEnQ = Enable ? 1 : 0;
    endtask

    task automatic checkOutput();
        for (int k = 0; k < 2; k++) begin
            checkValue($sformatf("addr%0d", k), 32'(addrO[k]), mAddr[k]);
            checkValue($sformatf("state%0d", k), 32'(stateO[k]), mState[k]);
            checkValue($sformatf("strobe%0d", k), 32'(strobeO[k]), mStrobe[k]);
            checkValue($sformatf("wrap%0d", k), 32'(wrapO[k]), mWrap[k]);
            checkValue($sformatf("err%0d", k), 32'(errO[k]), (LowAddr > HighAddr) ? 1 : 0);
        end
        if (wrapO[0] === 1'b1) wrapSeen0++;
        if (strobeO[0] === 1'b1) strobeSeen0++;
    endtask

    // One clock: model advances on the inputs now applied, DUT sampled 1 ns after the edge.
    task automatic applyStimulus();
        modelStep();
        @(posedge Clk);
        #1;
        checkOutput();
    endtask

    task automatic pulseTick();
        Enable = 1'b1;
        applyStimulus();
        Enable = 1'b0;
        applyStimulus();
    endtask

    initial begin
        int seqExp [5];
        seqExp = '{3, 4, 2, 3, 4};

        // Reset state, taken without any clock edge.
        #1 rstN = 1'b0;
        #1;
        modelReset();
        checkValue("rstAddr", 32'(addrO[0]), 0);
        checkValue("rstState", 32'(stateO[0]), 0);
        checkValue("rstStrobe", 32'(strobeO[0]), 0);
        checkValue("rstWrap", 32'(wrapO[0]), 0);
        #1 rstN = 1'b1;

        // Reset mid-run with Address=9.
        LowAddr = 5'd0; HighAddr = 5'd15; Run = 1'b1;
        LoadAddr = 5'd9; Load = 1'b1;
        applyStimulus();
        Load = 1'b0;
        checkValue("preRstAddr", 32'(addrO[0]), 9);
        #1 rstN = 1'b0;
        #1;
        modelReset();
        checkValue("midRstAddr", 32'(addrO[0]), 0);
        checkValue("midRstState", 32'(stateO[0]), 0);
        checkValue("midRstStrobe", 32'(strobeO[0]), 0);
        #1 rstN = 1'b1;

        // Looping up through window 2..4.
        LowAddr = 5'd2; HighAddr = 5'd4; Dir = 1'b0; Run = 1'b1;
        LoadAddr = 5'd2; Load = 1'b1;
        applyStimulus();
        Load = 1'b0;
        wrapSeen0 = 0;
        strobeSeen0 = 0;
        for (int i = 0; i < 5; i++) begin
            pulseTick();
            checkValue($sformatf("loopSeq%0d", i), 32'(addrO[0]), seqExp[i]);
        end
        checkValue("loopWrapCount", 32'(wrapSeen0), 1);
        checkValue("loopStrobeCount", 32'(strobeSeen0), 5);

        // One-shot down through window 0..3.
        LowAddr = 5'd0; HighAddr = 5'd3; Dir = 1'b1;
        LoadAddr = 5'd1; Load = 1'b1;
        applyStimulus();
        Load = 1'b0;
        pulseTick();
        checkValue("oneShotAddr1", 32'(addrO[1]), 0);
        Enable = 1'b1;
        applyStimulus();
        checkValue("oneShotDone", 32'(stateO[1]), 2);
        checkValue("oneShotWrap", 32'(wrapO[1]), 1);
        Enable = 1'b0;
        applyStimulus();
        pulseTick();
        checkValue("oneShotIgnored", 32'(addrO[1]), 0);
        checkValue("oneShotStill", 32'(stateO[1]), 2);
        Run = 1'b0;
        applyStimulus();
        checkValue("oneShotIdle", 32'(stateO[1]), 0);

        // Enable held high for 4 cycles gives a single step.
        Run = 1'b1; Dir = 1'b0; LowAddr = 5'd0; HighAddr = 5'd31;
        LoadAddr = 5'd5; Load = 1'b1;
        applyStimulus();
        Load = 1'b0;
        Enable = 1'b1;
        repeat (4) applyStimulus();
        Enable = 1'b0;
        applyStimulus();
        checkValue("heldEnable", 32'(addrO[0]), 6);
        // Load coinciding with a tick wins and the tick is dropped.
        Enable = 1'b1; LoadAddr = 5'd7; Load = 1'b1;
        applyStimulus();
        Load = 1'b0; Enable = 1'b0;
        applyStimulus();
        checkValue("loadBeatsTick", 32'(addrO[0]), 7);

        // Inverted window: ticks ignored; then snap into a repaired window.
        LowAddr = 5'd6; HighAddr = 5'd3;
        pulseTick();
        checkValue("errLevel", 32'(errO[0]), 1);
        checkValue("errHold", 32'(addrO[0]), 7);
        LowAddr = 5'd3; LoadAddr = 5'd1; Load = 1'b1;
        applyStimulus();
        Load = 1'b0;
        Enable = 1'b1;
        applyStimulus();
        checkValue("snapAddr", 32'(addrO[0]), 3);
        checkValue("snapWrap", 32'(wrapO[0]), 0);
        Enable = 1'b0;
        applyStimulus();

        // Full-range wrap at 31 -> 0.
        LowAddr = 5'd0; HighAddr = 5'd31; LoadAddr = 5'd31; Load = 1'b1;
        applyStimulus();
        Load = 1'b0;
        Enable = 1'b1;
        applyStimulus();
        checkValue("fullWrapAddr", 32'(addrO[0]), 0);
        checkValue("fullWrapPulse", 32'(wrapO[0]), 1);
        Enable = 1'b0;
        applyStimulus();

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            Enable   = $urandom_range(0, 1) == 1;
            Run      = $urandom_range(0, 9) != 0;
            Load     = $urandom_range(0, 19) == 0;
            LoadAddr = AW'($urandom_range(0, 31));
            if ($urandom_range(0, 15) == 0) Dir = ~Dir;
            if ($urandom_range(0, 24) == 0) begin
                LowAddr  = AW'($urandom_range(0, 31));
                HighAddr = AW'($urandom_range(0, 31));
            end
            applyStimulus();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
